// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: rx_tick at the oversample rate, tx_tick at the bit rate.
// Define BAUD_PRESET_EN to add the sel/sel_load preset divisor table.
module baud_tick_gen #(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DEFAULT_INT  = 54,
    parameter int unsigned DEFAULT_FRAC = 4
) (
    input  logic              CLK100MHZ,
    input  logic              resetn,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              rx_resync,
`ifdef BAUD_PRESET_EN
    input  logic [2:0]        sel,
    input  logic              sel_load,
`endif
    output logic              rx_tick,
    output logic              tx_tick,
    output logic [DIV_W-1:0]  div_int_q,
    output logic [FRAC_W-1:0] div_frac_q,
    output logic              cfg_err
);

    localparam int unsigned       OS_W    = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W:0]    CNT_ONE = (DIV_W+1)'(1);
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              init_q;
    logic              rx_tick_q, rx_tick_d;
    logic              tx_tick_q, tx_tick_d;
    logic [DIV_W-1:0]  div_int_d;
    logic [FRAC_W-1:0] div_frac_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_load;
    logic              restart;
    logic [DIV_W:0]    lim;
    logic              period_end;

`ifdef BAUD_PRESET_EN
    logic [DIV_W-1:0]  preset_int;
    logic [FRAC_W-1:0] preset_frac;

    // Presets assume a 100 MHz clock, 16x oversampling and FRAC_W = 4.
    always_comb begin
        preset_int  = DIV_W'(54);
        preset_frac = FRAC_W'(4);
        case (sel)
            3'd0: begin preset_int = DIV_W'(5208); preset_frac = FRAC_W'(5);  end
            3'd1: begin preset_int = DIV_W'(2604); preset_frac = FRAC_W'(3);  end
            3'd2: begin preset_int = DIV_W'(1302); preset_frac = FRAC_W'(1);  end
            3'd3: begin preset_int = DIV_W'(651);  preset_frac = FRAC_W'(1);  end
            3'd4: begin preset_int = DIV_W'(325);  preset_frac = FRAC_W'(8);  end
            3'd5: begin preset_int = DIV_W'(162);  preset_frac = FRAC_W'(12); end
            3'd6: begin preset_int = DIV_W'(108);  preset_frac = FRAC_W'(8);  end
            default: begin preset_int = DIV_W'(54); preset_frac = FRAC_W'(4); end
        endcase
    end

    assign cfg_load = div_load | sel_load;
`else
    assign cfg_load = div_load;
`endif

    // The cycle right after reset release restarts the phase just like a load does.
    assign restart    = cfg_load | rx_resync | init_q;
    assign lim        = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry_q};
    assign period_end = (cnt_q == lim - CNT_ONE);

    always_comb begin
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        cfg_err_d  = cfg_err_q;
        if (div_load) begin
            div_frac_d = div_frac;
            if (div_int < MIN_DIV) begin
                div_int_d = MIN_DIV;
                cfg_err_d = 1'b1;
            end else begin
                div_int_d = div_int;
            end
        end
`ifdef BAUD_PRESET_EN
        else if (sel_load) begin
            div_int_d  = preset_int;
            div_frac_d = preset_frac;
        end
`endif
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        os_cnt_d  = os_cnt_q;
        rx_tick_d = 1'b0;
        tx_tick_d = 1'b0;
        if (restart) begin
            cnt_d    = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            os_cnt_d = '0;
        end else if (en) begin
            if (period_end) begin
                cnt_d              = '0;
                {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, div_frac_q};
                rx_tick_d          = 1'b1;
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d  = '0;
                    tx_tick_d = 1'b1;
                end else begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            os_cnt_q   <= '0;
            init_q     <= 1'b1;
            rx_tick_q  <= 1'b0;
            tx_tick_q  <= 1'b0;
            div_int_q  <= DIV_W'(DEFAULT_INT);
            div_frac_q <= FRAC_W'(DEFAULT_FRAC);
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            os_cnt_q   <= os_cnt_d;
            init_q     <= 1'b0;
            rx_tick_q  <= rx_tick_d;
            tx_tick_q  <= tx_tick_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign rx_tick = rx_tick_q;
    assign tx_tick = tx_tick_q;
    assign cfg_err = cfg_err_q;

endmodule
